// File: rtl/pe_array_sched_pkg.sv
// Shared types, geometry constants and address helpers for the 7x7-by-3x3
// convolution scheduler.
package pe_array_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FLUSH = 3'd2,
        ST_FIRE  = 3'd3,
        ST_COMP  = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned ROW_W     = 3;
    localparam int unsigned WORD_W    = 4;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned XFER_W    = 5;
    localparam int unsigned NUM_ROWS  = 7;
    localparam int unsigned DATA_LEN  = 7;
    localparam int unsigned FILT_LEN  = 3;
    localparam int unsigned FILT_ROWS = 3;
    localparam int unsigned OUT_DIM   = 5;
    localparam int unsigned OUT_COUNT = OUT_DIM * OUT_DIM;
    localparam int unsigned DATA_BASE = 0;
    localparam int unsigned FILT_BASE = 49;

    // One ROM issue as tracked by the strobe delay line.
    typedef struct packed {
        logic valid;
        logic is_filt;
    } issue_t;

    // Rows 0..FILT_ROWS-1 also carry one filter row after the data row.
    function automatic logic [WORD_W-1:0] words_in_row(input logic [ROW_W-1:0] row);
        if (row < ROW_W'(FILT_ROWS)) begin
            return WORD_W'(DATA_LEN + FILT_LEN);
        end
        return WORD_W'(DATA_LEN);
    endfunction

    function automatic logic is_filt_word(input logic [WORD_W-1:0] word);
        return word >= WORD_W'(DATA_LEN);
    endfunction

    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ROW_W-1:0]  row,
                                                     input logic [WORD_W-1:0] word);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] w;
        r = ADDR_W'(row);
        w = ADDR_W'(word);
        if (!is_filt_word(word)) begin
            return ADDR_W'(DATA_BASE) + ADDR_W'(DATA_LEN) * r + w;
        end
        return ADDR_W'(FILT_BASE) + ADDR_W'(FILT_LEN) * r + (w - ADDR_W'(DATA_LEN));
    endfunction

endpackage

// File: rtl/pe_array_sched_lat_pipe.sv
// ROM-latency delay line turning issued reads into row-buffer shift strobes.
module sched_lat_pipe
    import pe_array_sched_pkg::*;
#(
    parameter int unsigned ROM_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  issue_t issue_i,
    output logic   shift_data_o,
    output logic   shift_filt_o
);

    localparam int unsigned LAST = ROM_LAT - 1;

    issue_t stage_q [ROM_LAT];
    logic   shift_data_q;
    logic   shift_filt_q;

    // issue_i is the next-cycle issue, so ROM_LAT stages plus the strobe
    // register land the strobe ROM_LAT cycles after rom_read is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                stage_q[i] <= '0;
            end
            shift_data_q <= 1'b0;
            shift_filt_q <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                stage_q[i] <= '0;
            end
            shift_data_q <= 1'b0;
            shift_filt_q <= 1'b0;
        end else begin
            stage_q[0] <= issue_i;
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            shift_data_q <= stage_q[LAST].valid & ~stage_q[LAST].is_filt;
            shift_filt_q <= stage_q[LAST].valid &  stage_q[LAST].is_filt;
        end
    end

    assign shift_data_o = shift_data_q;
    assign shift_filt_o = shift_filt_q;

endmodule

// File: rtl/pe_array_sched.sv
// Scheduler for one 7x7-by-3x3 convolution: ROM row fetch, PE row loading,
// wait for the array, then a 25-element handshaked output drain.
module pe_array_sched
    import pe_array_sched_pkg::*;
#(
    parameter int unsigned ROM_LAT      = 2,
    parameter int unsigned COMP_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clr,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_read,
    output logic                buf_clr,
    output logic                buf_shift_data,
    output logic                buf_shift_filt,
    output logic [NUM_ROWS-1:0] row_en,
    input  logic                array_done,
    output logic [SEL_W-1:0]    out_col,
    output logic [SEL_W-1:0]    out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int unsigned TMO_W = (COMP_TIMEOUT > 1) ? $clog2(COMP_TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SEL_W-1:0]    col_q, col_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [XFER_W-1:0]   xfer_q, xfer_d;

    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                rom_read_q, rom_read_d;
    logic                buf_clr_q, buf_clr_d;
    logic [NUM_ROWS-1:0] row_en_q, row_en_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    issue_t              issue_d;

    // Next-state logic; outputs are decoded from the next state so that
    // every output is a flop that moves together with the state.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        word_d   = word_q;
        lat_d    = lat_q;
        tmo_d    = tmo_q;
        col_d    = col_q;
        idx_d    = idx_q;
        xfer_d   = xfer_q;
        buf_clr_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            row_d   = '0;
            word_d  = '0;
            lat_d   = '0;
            tmo_d   = '0;
            col_d   = '0;
            idx_d   = '0;
            xfer_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_FETCH;
                        row_d     = '0;
                        word_d    = '0;
                        buf_clr_d = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (word_q == words_in_row(row_q) - WORD_W'(1)) begin
                        state_d = ST_FLUSH;
                        word_d  = '0;
                        lat_d   = '0;
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (lat_q == LAT_W'(ROM_LAT - 1)) begin
                        state_d = ST_FIRE;
                        lat_d   = '0;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                ST_FIRE: begin
                    if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                        state_d = ST_COMP;
                        row_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_FETCH;
                        row_d   = row_q + ROW_W'(1);
                        word_d  = '0;
                    end
                end
                ST_COMP: begin
                    if (array_done) begin
                        state_d = ST_DRAIN;
                        tmo_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        xfer_d  = '0;
                    end else if (tmo_q == TMO_W'(COMP_TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (xfer_q == XFER_W'(OUT_COUNT - 1)) begin
                            state_d = ST_IDLE;
                            col_d   = '0;
                            idx_d   = '0;
                            xfer_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            xfer_d = xfer_q + XFER_W'(1);
                            if (idx_q == SEL_W'(OUT_DIM - 1)) begin
                                idx_d = '0;
                                col_d = col_q + SEL_W'(1);
                            end else begin
                                idx_d = idx_q + SEL_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rom_read_d     = (state_d == ST_FETCH);
        rom_addr_d     = rom_read_d ? fetch_addr(row_d, word_d) : '0;
        issue_d.valid  = rom_read_d;
        issue_d.is_filt = rom_read_d && is_filt_word(word_d);
        row_en_d       = (state_d == ST_FIRE) ? (NUM_ROWS'(1) << row_d) : '0;
        out_valid_d    = (state_d == ST_DRAIN);
        busy_d         = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            word_q      <= '0;
            lat_q       <= '0;
            tmo_q       <= '0;
            col_q       <= '0;
            idx_q       <= '0;
            xfer_q      <= '0;
            rom_addr_q  <= '0;
            rom_read_q  <= 1'b0;
            buf_clr_q   <= 1'b0;
            row_en_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            word_q      <= word_d;
            lat_q       <= lat_d;
            tmo_q       <= tmo_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            xfer_q      <= xfer_d;
            rom_addr_q  <= rom_addr_d;
            rom_read_q  <= rom_read_d;
            buf_clr_q   <= buf_clr_d;
            row_en_q    <= row_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // clr flushes in-flight issues so no stale shift strobe follows an abort.
    sched_lat_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_lat_pipe (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (clr),
        .issue_i      (issue_d),
        .shift_data_o (buf_shift_data),
        .shift_filt_o (buf_shift_filt)
    );

    assign rom_addr  = rom_addr_q;
    assign rom_read  = rom_read_q;
    assign buf_clr   = buf_clr_q;
    assign row_en    = row_en_q;
    assign out_col   = col_q;
    assign out_idx   = idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: nominal job, backpressure, timeout,
// abort, start-while-busy and asynchronous reset in DRAIN.
module tb_pe_array_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clr;
    logic [5:0] rom_addr;
    logic       rom_read;
    logic       buf_clr;
    logic       buf_shift_data;
    logic       buf_shift_filt;
    logic [6:0] row_en;
    logic       array_done;
    logic [2:0] out_col;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Row-enable cycles with start in cycle 0.
    localparam int RE [7] = '{13, 26, 39, 49, 59, 69, 79};

    pe_array_sched #(
        .ROM_LAT      (2),
        .COMP_TIMEOUT (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .clr            (clr),
        .rom_addr       (rom_addr),
        .rom_read       (rom_read),
        .buf_clr        (buf_clr),
        .buf_shift_data (buf_shift_data),
        .buf_shift_filt (buf_shift_filt),
        .row_en         (row_en),
        .array_done     (array_done),
        .out_col        (out_col),
        .out_idx        (out_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] pk(input logic bz, input logic rd, input logic [5:0] ad,
                                       input logic bc, input logic sd, input logic sf,
                                       input logic [6:0] re, input logic ov,
                                       input logic [2:0] oc, input logic [2:0] oi,
                                       input logic dn, input logic er);
        return {bz, rd, ad, bc, sd, sf, re, ov, oc, oi, dn, er};
    endfunction

    function automatic logic [26:0] obs();
        return pk(busy, rom_read, rom_addr, buf_clr, buf_shift_data, buf_shift_filt,
                  row_en, out_valid, out_col, out_idx, done, err);
    endfunction

    // Expected ROM issue in cycle c of a job started in cycle 0.
    function automatic void issue_at(input int c, output logic rd, output int a, output logic f);
        rd = 1'b0;
        a  = 0;
        f  = 1'b0;
        for (int r = 0; r < 7; r++) begin
            int fs;
            int n;
            fs = (r == 0) ? 1 : RE[r-1] + 1;
            n  = (r < 3) ? 10 : 7;
            if (c >= fs && c < fs + n) begin
                int w;
                w  = c - fs;
                rd = 1'b1;
                f  = (w >= 7);
                a  = f ? (49 + 3 * r + (w - 7)) : (7 * r + w);
            end
        end
    endfunction

    function automatic logic [26:0] fetch_exp(input int c);
        logic       rd, f, rd2, f2;
        int         a, a2;
        logic [6:0] ren;
        issue_at(c, rd, a, f);
        issue_at(c - 2, rd2, a2, f2);
        ren = '0;
        for (int r = 0; r < 7; r++) begin
            if (c == RE[r]) ren[r] = 1'b1;
        end
        return pk(1'b1, rd, 6'(a), c == 1, rd2 && !f2, rd2 && f2, ren,
                  1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [26:0] o, input logic [26:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles 1..80 of a job whose start was driven in cycle 0.
    task automatic fetch_phase(input int clr_at, input logic extra);
        for (int c = 1; c <= 80; c++) begin
            tick();
            start = extra && (c == 5 || c == 60);
            chk($sformatf("fetch_c%0d", c), obs(), fetch_exp(c));
            if (c == clr_at) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("abort_idle_%0d", k), obs(), '0);
                    tick();
                end
                break;
            end
        end
    endtask

    // Called in the first DRAIN cycle; ready follows 1,0,0,1 when bp is set.
    task automatic drain(input logic bp);
        int         k;
        int         p;
        logic [3:0] pat;
        k   = 0;
        p   = 0;
        pat = 4'b1001;
        for (int n = 0; n < 200 && k < 25; n++) begin
            out_ready = bp ? pat[p % 4] : 1'b1;
            chk($sformatf("drain_k%0d", k), obs(),
                pk(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1,
                   3'(k / 5), 3'(k % 5), 1'b0, 1'b0));
            if (out_ready) k++;
            p++;
            tick();
        end
        chk("drain_count", 27'(k), 27'(25));
        out_ready = 1'b1;
        chk("drain_done", obs(), pk(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0,
                                    3'd0, 3'd0, 1'b1, 1'b0));
        tick();
        chk("drain_after", obs(), '0);
    endtask

    task automatic nominal_job(input logic extra);
        start = 1'b1;
        fetch_phase(0, extra);
        for (int c = 81; c <= 90; c++) begin
            tick();
            chk($sformatf("comp_c%0d", c), obs(),
                pk(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
            if (c == 90) array_done = 1'b1;
        end
        tick();
        drain(1'b0);
        array_done = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        clr        = 1'b0;
        array_done = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("reset_state", obs(), '0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", obs(), '0);

        // Nominal job.
        nominal_job(1'b0);

        // Backpressure, with array_done already high at COMP entry.
        array_done = 1'b1;
        start      = 1'b1;
        fetch_phase(0, 1'b0);
        tick();
        drain(1'b1);
        array_done = 1'b0;
        tick();

        // Timeout: err 255 cycles after COMP entry in cycle 80.
        start = 1'b1;
        fetch_phase(0, 1'b0);
        for (int c = 81; c <= 336; c++) begin
            tick();
            if (c < 335)
                chk($sformatf("tmo_c%0d", c), obs(),
                    pk(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
            else if (c == 335)
                chk("tmo_err", obs(),
                    pk(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1));
            else
                chk("tmo_after", obs(), '0);
        end

        // Abort in cycle 30, then clr beats a simultaneous start.
        start = 1'b1;
        fetch_phase(30, 1'b0);
        start = 1'b1;
        clr   = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        chk("clr_beats_start", obs(), '0);
        tick();
        chk("clr_beats_start2", obs(), '0);
        nominal_job(1'b0);

        // Start pulses while busy are ignored.
        nominal_job(1'b1);

        // Async reset asserted between edges while stalled in DRAIN.
        array_done = 1'b1;
        out_ready  = 1'b0;
        start      = 1'b1;
        fetch_phase(0, 1'b0);
        tick();
        chk("arst_in_drain", 27'(out_valid), 27'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_immediate", obs(), '0);
        tick();
        rst        = 1'b0;
        array_done = 1'b0;
        out_ready  = 1'b1;
        tick();
        chk("arst_idle", obs(), '0);
        nominal_job(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
